// File: rtl/min_sec_timebase.sv
// Minutes/seconds timebase: a prescaler divides clk down to one-second ticks,
// which drive a 0-59 seconds counter and a 0-59 minutes counter with wrap pulses.
module min_sec_timebase #(
    parameter int TICKS_PER_SEC = 100000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       set_load,
    input  logic [5:0] set_min,
    input  logic [5:0] set_sec,
    output logic [5:0] seconds,
    output logic [5:0] minutes,
    output logic       tick_1s,
    output logic       tick_1m,
    output logic       tick_1h,
    output logic       set_err
);

    localparam int PW = $clog2(TICKS_PER_SEC);
    localparam logic [PW-1:0] PRE_LAST = PW'(TICKS_PER_SEC - 1);

    logic [PW-1:0] prescaler;
    logic          load_ok;
    logic          terminal;

    assign load_ok  = set_load && (set_min <= 6'd59) && (set_sec <= 6'd59);
    assign terminal = (prescaler == PRE_LAST);

    // An accepted load overrides any advance on the same edge; a rejected one
    // only raises set_err and lets counting proceed.
    always_ff @(posedge clk) begin
        if (rst) begin
            prescaler <= '0;
            seconds   <= 6'd0;
            minutes   <= 6'd0;
            tick_1s   <= 1'b0;
            tick_1m   <= 1'b0;
            tick_1h   <= 1'b0;
            set_err   <= 1'b0;
        end else begin
            tick_1s <= 1'b0;
            tick_1m <= 1'b0;
            tick_1h <= 1'b0;
            set_err <= 1'b0;
            if (load_ok) begin
                minutes   <= set_min;
                seconds   <= set_sec;
                prescaler <= '0;
            end else begin
                if (set_load) begin
                    set_err <= 1'b1;
                end
                if (en) begin
                    if (terminal) begin
                        prescaler <= '0;
                        tick_1s   <= 1'b1;
                        if (seconds >= 6'd59) begin
                            seconds <= 6'd0;
                            tick_1m <= 1'b1;
                            if (minutes >= 6'd59) begin
                                minutes <= 6'd0;
                                tick_1h <= 1'b1;
                            end else begin
                                minutes <= minutes + 6'd1;
                            end
                        end else begin
                            seconds <= seconds + 6'd1;
                        end
                    end else begin
                        prescaler <= prescaler + PW'(1);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_min_sec_timebase.sv
// Scoreboard bench for min_sec_timebase: a time-of-hour model in plain seconds
// predicts every cycle's outputs, and a monitor checks them as the DUT presents them.
module tb_min_sec_timebase;

    localparam int TPS = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b0;
    logic       set_load = 1'b0;
    logic [5:0] set_min = 6'd0;
    logic [5:0] set_sec = 6'd0;
    logic [5:0] seconds;
    logic [5:0] minutes;
    logic       tick_1s;
    logic       tick_1m;
    logic       tick_1h;
    logic       set_err;

    typedef struct packed {
        logic [5:0] sec;
        logic [5:0] min;
        logic       t1s;
        logic       t1m;
        logic       t1h;
        logic       err;
    } exp_t;

    exp_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;

    // Reference state: elapsed seconds within the hour and cycles into the second.
    int   m_total = 0;
    int   m_pre = 0;

    min_sec_timebase #(.TICKS_PER_SEC(TPS)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .set_load (set_load),
        .set_min  (set_min),
        .set_sec  (set_sec),
        .seconds  (seconds),
        .minutes  (minutes),
        .tick_1s  (tick_1s),
        .tick_1m  (tick_1m),
        .tick_1h  (tick_1h),
        .set_err  (set_err)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [5:0] actual, input logic [5:0] expected);
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s at %0t: got %0d, expected %0d", name, $time, actual, expected);
        end
    endtask

    // Drive one cycle of inputs and predict the outputs after the next edge.
    task automatic applyStimulus(input logic r, input logic e, input logic ld,
                                 input int mn, input int sc);
        exp_t x;
        @(negedge clk);
        rst      = r;
        en       = e;
        set_load = ld;
        set_min  = 6'(mn);
        set_sec  = 6'(sc);
        x = '0;
        if (r) begin
            m_total = 0;
            m_pre   = 0;
        end else if (ld && mn <= 59 && sc <= 59) begin
            m_total = mn * 60 + sc;
            m_pre   = 0;
        end else begin
            if (ld) x.err = 1'b1;
            if (e) begin
                if (m_pre == TPS - 1) begin
                    m_pre   = 0;
                    m_total = (m_total + 1) % 3600;
                    x.t1s   = 1'b1;
                    x.t1m   = (m_total % 60 == 0);
                    x.t1h   = (m_total == 0);
                end else begin
                    m_pre++;
                end
            end
        end
        x.sec = 6'(m_total % 60);
        x.min = 6'(m_total / 60);
        exp_q.push_back(x);
    endtask

    always @(posedge clk) begin
        exp_t x;
        #1;
        if (exp_q.size() > 0) begin
            x = exp_q.pop_front();
            vectors++;
            checkOutput("seconds", seconds, x.sec);
            checkOutput("minutes", minutes, x.min);
            checkOutput("tick_1s", {5'd0, tick_1s}, {5'd0, x.t1s});
            checkOutput("tick_1m", {5'd0, tick_1m}, {5'd0, x.t1m});
            checkOutput("tick_1h", {5'd0, tick_1h}, {5'd0, x.t1h});
            checkOutput("set_err", {5'd0, set_err}, {5'd0, x.err});
        end
    end

    initial begin
        // Reset, then free-run through a few seconds.
        applyStimulus(1, 1, 0, 0, 0);
        for (int i = 0; i < 12; i++) applyStimulus(0, 1, 0, 0, 0);

        // Hour rollover from 59:58.
        applyStimulus(0, 1, 1, 59, 58);
        for (int i = 0; i < 10; i++) applyStimulus(0, 1, 0, 0, 0);

        // Rejected load keeps counting.
        applyStimulus(0, 1, 1, 12, 60);
        applyStimulus(0, 1, 1, 63, 10);
        for (int i = 0; i < 5; i++) applyStimulus(0, 1, 0, 0, 0);

        // Freeze with en=0 mid-second.
        applyStimulus(0, 1, 1, 3, 3);
        applyStimulus(0, 1, 0, 0, 0);
        applyStimulus(0, 1, 0, 0, 0);
        for (int i = 0; i < 10; i++) applyStimulus(0, 0, 0, 0, 0);
        for (int i = 0; i < 6; i++) applyStimulus(0, 1, 0, 0, 0);

        // Accepted load on the terminal prescaler cycle, then load with en low.
        applyStimulus(0, 1, 1, 0, 0);
        for (int i = 0; i < 3; i++) applyStimulus(0, 1, 0, 0, 0);
        applyStimulus(0, 1, 1, 5, 5);
        for (int i = 0; i < 5; i++) applyStimulus(0, 1, 0, 0, 0);
        applyStimulus(0, 0, 1, 40, 59);
        applyStimulus(0, 0, 0, 0, 0);

        // Reset beats a simultaneous load at 30:30, and a rejected load.
        applyStimulus(0, 1, 1, 30, 30);
        applyStimulus(1, 1, 1, 30, 30);
        applyStimulus(1, 1, 1, 61, 30);
        for (int i = 0; i < 6; i++) applyStimulus(0, 1, 0, 0, 0);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            applyStimulus($urandom_range(0, 199) == 0,
                          $urandom_range(0, 9) < 8,
                          $urandom_range(0, 19) == 0,
                          ($urandom_range(0, 3) == 0) ? 59 : int'($urandom_range(0, 63)),
                          ($urandom_range(0, 3) == 0) ? 59 : int'($urandom_range(0, 63)));
        end

        repeat (3) @(posedge clk);
        #2;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL drain: %0d predictions left unchecked, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/min_sec_timebase.md
MIN_SEC_TIMEBASE -- requirements
Module: min_sec_timebase

Interface
REQ-001 Parameter TICKS_PER_SEC, default 100000000, clk cycles per second; legal range >= 2.
REQ-002 clk  input  1  system clock; all state updates on the rising edge.
REQ-003 rst  input  1  synchronous, active-high reset; sampled on rising clk edge.
REQ-004 en  input  1  count enable; low freezes the prescaler, seconds and minutes.
REQ-005 set_load  input  1  one-cycle request to load set_min/set_sec.
REQ-006 set_min  input  6  minutes value to load, legal 0-59.
REQ-007 set_sec  input  6  seconds value to load, legal 0-59.
REQ-008 seconds  output  6  current seconds, 0-59, registered.
REQ-009 minutes  output  6  current minutes, 0-59, registered.
REQ-010 tick_1s  output  1  one-cycle pulse on each seconds advance.
REQ-011 tick_1m  output  1  one-cycle pulse when seconds wrap from 59 to 0.
REQ-012 tick_1h  output  1  one-cycle pulse when minutes wrap from 59 to 0; drives the hours counter's tick_1h.
REQ-013 set_err  output  1  one-cycle pulse when a set_load is rejected.

Function
REQ-014 Prescaler of width clog2(TICKS_PER_SEC) shall count 0 to TICKS_PER_SEC-1 while en=1 and hold while en=0.
REQ-015 On the edge where prescaler == TICKS_PER_SEC-1 and en=1: prescaler -> 0, seconds advance, tick_1s registered high for exactly the next cycle.
REQ-016 Seconds advance: 0-58 increments by 1; 59 -> 0 with tick_1m high in the same cycle as seconds=0.
REQ-017 Minutes shall increment only on a seconds 59 -> 0 wrap: 0-58 increments by 1; 59 -> 0 with tick_1h high in the same cycle as minutes=0.
REQ-018 tick_1s, tick_1m and tick_1h shall be registered and coincide with the cycle that first shows the new seconds/minutes value; tick_1h implies tick_1m implies tick_1s.
REQ-019 All ticks shall be low in every cycle without an advance, including any cycle with en=0.
REQ-020 Accepted set_load (set_min <= 59 and set_sec <= 59): on the next edge minutes=set_min, seconds=set_sec, prescaler=0; no tick pulses that cycle.
REQ-021 Rejected set_load (either field > 59): counters and prescaler unchanged by the load, normal counting continues, set_err high for exactly the next cycle.
REQ-022 set_load coinciding with a terminal prescaler count: an accepted load wins, the advance and its ticks are discarded; a rejected load does not block the advance.
REQ-023 set_load shall be honoured regardless of en.
REQ-024 seconds and minutes shall never hold a value above 59.

Reset
REQ-025 rst=1 on a rising edge: prescaler=0, seconds=0, minutes=0, tick_1s=0, tick_1m=0, tick_1h=0, set_err=0.
REQ-026 rst has priority over set_load and en; counting resumes from 00:00 with a full TICKS_PER_SEC cycles before the first tick_1s.
REQ-027 Reset mid-second discards the partial prescaler count; no tick is emitted in the cycle after reset.

Verification (TICKS_PER_SEC=4)
REQ-028 rst 1 cycle, en=1 -> tick_1s first high 4 cycles after rst drops, seconds=1; then every 4 cycles.
REQ-029 set_load min=59 sec=58, en=1 -> after 4 cycles seconds=59, tick_1s only; after 8 cycles seconds=0 minutes=0 with tick_1s, tick_1m, tick_1h all high for one cycle.
REQ-030 set_load min=12 sec=60 -> set_err one cycle, minutes/seconds unchanged, counting continues.
REQ-031 en=0 for 10 cycles at prescaler=2 -> no ticks, values frozen; en=1 -> tick_1s after 2 more cycles.
REQ-032 set_load min=5 sec=5 on the terminal prescaler cycle -> next cycle minutes=5 seconds=5, no ticks, next tick_1s 4 cycles later.
REQ-033 rst asserted with set_load active at 30:30 -> 00:00, no set_err, no ticks.
